// File: rtl/pipe_front_regs.sv
// Y86-64 front-end pipeline registers (F predicted PC, D, E) with per-stage
// stall/bubble handling, saturating hazard counters and a sticky control-error flag.
module pipe_front_regs #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             F_stall,
  input  logic             F_bubble,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [WIDTH-1:0] f_predPC,
  input  logic [2:0]       f_stat,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [WIDTH-1:0] f_valC,
  input  logic [WIDTH-1:0] f_valP,
  input  logic [2:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [WIDTH-1:0] F_predPC,
  output logic [2:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [WIDTH-1:0] D_valC,
  output logic [WIDTH-1:0] D_valP,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [WIDTH-1:0] E_valC,
  output logic [WIDTH-1:0] E_valA,
  output logic [WIDTH-1:0] E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic             ctrl_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
);

  localparam logic [3:0] I_NOP = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic illegal;
  assign illegal = (F_stall & F_bubble) | (D_stall & D_bubble) | (E_stall & E_bubble);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_predPC <= '0;
    end else if (!F_stall) begin
      F_predPC <= F_bubble ? '0 : f_predPC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D_stat  <= S_AOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      if (D_bubble) begin
        D_stat  <= S_AOK;
        D_icode <= I_NOP;
        D_ifun  <= 4'h0;
        D_rA    <= RNONE;
        D_rB    <= RNONE;
        D_valC  <= '0;
        D_valP  <= '0;
      end else begin
        D_stat  <= f_stat;
        D_icode <= f_icode;
        D_ifun  <= f_ifun;
        D_rA    <= f_rA;
        D_rB    <= f_rB;
        D_valC  <= f_valC;
        D_valP  <= f_valP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!E_stall) begin
      if (E_bubble) begin
        E_stat  <= S_AOK;
        E_icode <= I_NOP;
        E_ifun  <= 4'h0;
        E_valC  <= '0;
        E_valA  <= '0;
        E_valB  <= '0;
        E_dstE  <= RNONE;
        E_dstM  <= RNONE;
        E_srcA  <= RNONE;
        E_srcB  <= RNONE;
      end else begin
        E_stat  <= d_stat;
        E_icode <= d_icode;
        E_ifun  <= d_ifun;
        E_valC  <= d_valC;
        E_valA  <= d_valA;
        E_valB  <= d_valB;
        E_dstE  <= d_dstE;
        E_dstM  <= d_dstM;
        E_srcA  <= d_srcA;
        E_srcB  <= d_srcB;
      end
    end
  end

  // Counters stop at all-ones so long runs never alias back to small values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_err      <= 1'b0;
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (illegal) ctrl_err <= 1'b1;
      if (D_stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_ONE;
      if (E_bubble && bubble_cycles != '1) bubble_cycles <= bubble_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed-vector bench for pipe_front_regs; counters narrowed to 4 bits so
// saturation is reachable in a short run.
module tb_pipe_front_regs;
  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic F_stall, F_bubble, D_stall, D_bubble, E_stall, E_bubble;
  logic [WIDTH-1:0] f_predPC, f_valC, f_valP, d_valC, d_valA, d_valB;
  logic [2:0] f_stat, d_stat;
  logic [3:0] f_icode, f_ifun, f_rA, f_rB, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [WIDTH-1:0] F_predPC, D_valC, D_valP, E_valC, E_valA, E_valB;
  logic [2:0] D_stat, E_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic ctrl_err;
  logic [CNT_W-1:0] stall_cycles, bubble_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_front_regs #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .F_stall(F_stall), .F_bubble(F_bubble), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .ctrl_err(ctrl_err), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    F_stall = 0; F_bubble = 0; D_stall = 0; D_bubble = 0; E_stall = 0; E_bubble = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " F_predPC"}, F_predPC, 0);
    check({tag, " D_icode"}, D_icode, 4'h1);
    check({tag, " E_icode"}, E_icode, 4'h1);
    check({tag, " D_rA"}, D_rA, 4'hF);
    check({tag, " E_dstM"}, E_dstM, 4'hF);
    check({tag, " E_stat"}, E_stat, 3'd1);
    check({tag, " ctrl_err"}, ctrl_err, 0);
    check({tag, " stall_cycles"}, stall_cycles, 0);
    check({tag, " bubble_cycles"}, bubble_cycles, 0);
  endtask

  initial begin
    rst = 1'b1;
    clear_ctrl();
    f_predPC = 0; f_stat = 3'd1; f_icode = 0; f_ifun = 0; f_rA = 4'h2; f_rB = 4'h3;
    f_valC = 0; f_valP = 64'h8;
    d_stat = 3'd1; d_icode = 0; d_ifun = 0; d_valC = 0; d_valA = 64'hAA; d_valB = 64'hBB;
    d_dstE = 4'h3; d_dstM = 4'h4; d_srcA = 4'h5; d_srcB = 4'h6;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;

    // Normal flow
    f_icode = 4'h3; f_valC = 64'h10; f_predPC = 64'h100; d_icode = 4'h4;
    step();
    check("flow1 D_icode", D_icode, 4'h3);
    check("flow1 D_valC", D_valC, 64'h10);
    check("flow1 F_predPC", F_predPC, 64'h100);
    check("flow1 E_icode", E_icode, 4'h4);
    f_icode = 4'h6; d_icode = 4'h8; d_dstE = 4'h3;
    step();
    check("flow2 D_icode", D_icode, 4'h6);
    check("flow2 E_icode", E_icode, 4'h8);
    check("flow2 E_dstE", E_dstE, 4'h3);
    check("flow2 E_valA", E_valA, 64'hAA);

    // Load-use hazard
    f_icode = 4'h5; f_predPC = 64'h200;
    step();
    check("lu pre D_icode", D_icode, 4'h5);
    f_icode = 4'h7; f_predPC = 64'h300;
    F_stall = 1; D_stall = 1; E_bubble = 1;
    step();
    clear_ctrl();
    check("lu F_predPC", F_predPC, 64'h200);
    check("lu D_icode", D_icode, 4'h5);
    check("lu E_icode", E_icode, 4'h1);
    check("lu E_dstE", E_dstE, 4'hF);
    check("lu E_valA", E_valA, 0);
    check("lu stall_cycles", stall_cycles, 1);
    check("lu bubble_cycles", bubble_cycles, 1);
    check("lu ctrl_err", ctrl_err, 0);

    // Mispredict
    f_icode = 4'h6; d_icode = 4'h7;
    step();
    check("mp pre D_icode", D_icode, 4'h6);
    check("mp pre E_icode", E_icode, 4'h7);
    f_predPC = 64'h400; D_bubble = 1; E_bubble = 1;
    step();
    clear_ctrl();
    check("mp D_icode", D_icode, 4'h1);
    check("mp E_icode", E_icode, 4'h1);
    check("mp D_rA", D_rA, 4'hF);
    check("mp D_valP", D_valP, 0);
    check("mp F_predPC", F_predPC, 64'h400);
    check("mp bubble_cycles", bubble_cycles, 2);
    check("mp stall_cycles", stall_cycles, 1);

    // F bubble, then E stall holding E while D keeps loading
    F_bubble = 1; f_icode = 4'h2; d_icode = 4'h4;
    step();
    clear_ctrl();
    check("fb F_predPC", F_predPC, 0);
    check("fb D_icode", D_icode, 4'h2);
    check("fb E_icode", E_icode, 4'h4);
    E_stall = 1; d_icode = 4'h9; f_icode = 4'hA;
    step();
    clear_ctrl();
    check("es E_icode", E_icode, 4'h4);
    check("es D_icode", D_icode, 4'hA);
    f_icode = 4'h2;
    step();

    // Illegal stall+bubble on D
    D_stall = 1; D_bubble = 1; f_icode = 4'h3;
    step();
    clear_ctrl();
    check("ill D_icode", D_icode, 4'h2);
    check("ill ctrl_err", ctrl_err, 1);
    check("ill stall_cycles", stall_cycles, 2);
    step();
    check("ill sticky ctrl_err", ctrl_err, 1);
    check("ill D_icode reload", D_icode, 4'h3);

    // Saturation
    D_stall = 1; E_bubble = 1;
    for (int i = 0; i < 20; i++) step();
    clear_ctrl();
    check("sat bubble_cycles", bubble_cycles, 4'hF);
    check("sat stall_cycles", stall_cycles, 4'hF);
    step();
    check("sat hold bubble_cycles", bubble_cycles, 4'hF);
    check("sat ctrl_err", ctrl_err, 1);

    // Asynchronous reset mid-cycle, checked before the next edge
    f_predPC = 64'h500; f_icode = 4'h3; d_icode = 4'h6;
    step();
    check("pre-rst F_predPC", F_predPC, 64'h500);
    #2 rst = 1'b1;
    #1;
    check_reset_state("async");
    #1 rst = 1'b0;
    step();
    check("post-rst D_icode", D_icode, 4'h3);
    check("post-rst E_icode", E_icode, 4'h6);
    check("post-rst F_predPC", F_predPC, 64'h500);
    check("post-rst ctrl_err", ctrl_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_front_regs.md
# pipe_front_regs

Front-end pipeline register bank for the Y86-64 pipelined processor. It holds the F (predicted PC), D, and E stage registers and applies the per-stage stall/bubble commands produced by the pipeline control logic. Each stage either loads, holds, or takes a NOP bubble. The bank also keeps saturating hazard counters and a sticky flag for illegal stall/bubble combinations.

## Interface
Parameters:
- `WIDTH`, 64: PC/data word width.
- `CNT_W`, 16: width of the hazard counters.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `F_stall`, `F_bubble`, `D_stall`, `D_bubble`, `E_stall`, `E_bubble`  in  1 each  stage control commands.
- `f_predPC`  in  WIDTH  next predicted PC from fetch.
- `f_stat`  in  3  fetch status.
- `f_icode`, `f_ifun`, `f_rA`, `f_rB`  in  4 each  fetched fields.
- `f_valC`, `f_valP`  in  WIDTH  fetched constant and next PC.
- `d_stat`  in  3  decode-stage status.
- `d_icode`, `d_ifun`  in  4 each  decode-stage instruction fields.
- `d_valC`, `d_valA`, `d_valB`  in  WIDTH  decode-stage values.
- `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB`  in  4 each  decode-stage register IDs.
- `F_predPC`  out  WIDTH  registered predicted PC.
- `D_stat`, `D_icode`, `D_ifun`, `D_rA`, `D_rB`, `D_valC`, `D_valP`  out  D register contents.
- `E_stat`, `E_icode`, `E_ifun`, `E_valC`, `E_valA`, `E_valB`, `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB`  out  E register contents.
- `ctrl_err`  out  1  sticky flag for an illegal control combination.
- `stall_cycles`  out  CNT_W  count of cycles with `D_stall=1`.
- `bubble_cycles`  out  CNT_W  count of cycles with `E_bubble=1`.

## Operation
Constants:
- NOP icode = 4'h1, ifun = 0.
- RNONE = 4'hF.
- Stat AOK = 3'd1.

Bubble values:
- D bubble: `stat=AOK`, `icode=NOP`, `ifun=0`, `rA=rB=RNONE`, `valC=valP=0`.
- E bubble: `stat=AOK`, `icode=NOP`, `ifun=0`, `valC=valA=valB=0`, `dstE=dstM=srcA=srcB=RNONE`.

Per-stage rule at each rising edge, applied independently to F, D and E:
- stall=1: hold the current contents. Stall wins over bubble.
- stall=0, bubble=1: load the bubble value. For F, the bubble value is `F_predPC=0`.
- stall=0, bubble=0: load the stage inputs (`f_*` into D, `d_*` into E, `f_predPC` into F).

Control error:
- `ctrl_err` sets on any edge where a stage has stall=1 and bubble=1 at the same time.
- It stays set until `rst`. The held contents still follow the stall-wins rule.

Counters:
- `stall_cycles` increments on each edge with `D_stall=1`.
- `bubble_cycles` increments on each edge with `E_bubble=1`.
- Both saturate at all-ones and never wrap.

## Timing
- All outputs are registered. A command sampled at edge k is visible after edge k; there is no combinational path from inputs to outputs.
- Reset (asynchronous, takes effect immediately regardless of `clk`):
  - `F_predPC=0`.
  - D and E registers take their bubble values.
  - `ctrl_err=0`, both counters 0.
- Reset mid-operation discards in-flight contents. The first edge after `rst` deasserts behaves as a normal edge with the sampled commands.
- Load-use hazard (`F_stall=D_stall=E_bubble=1`): F and D hold; E becomes a bubble. This persists for exactly as many cycles as the commands are asserted.
- Mispredict (`D_bubble=E_bubble=1`): both D and E become bubbles on the same edge.
- `E_stall` is honoured even though current control logic drives it to 0.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle. Required: `F_predPC=0`, `D_icode=E_icode=4'h1`, `D_rA=E_dstM=4'hF`, `ctrl_err=0`, counters 0, all without waiting for a clock edge.
- Normal flow: `f_icode=3`, `f_valC=64'h10`, then `f_icode=6`, all controls 0. Required: `D_icode=3` after edge 1; `D_icode=6` and `E_icode` equal to `d_icode` after edge 2.
- Load-use: with `D_icode=5`, assert `F_stall=D_stall=E_bubble=1` for 1 cycle. Required: `F_predPC` and `D_icode=5` unchanged; `E_icode=1`, `E_dstE=4'hF`; `stall_cycles=1`, `bubble_cycles=1`.
- Mispredict: with `D_icode=6` and `E_icode=7`, assert `D_bubble=E_bubble=1`. Required: `D_icode=E_icode=1`; `F_predPC` loads `f_predPC`.
- Illegal combination: `D_stall=D_bubble=1` with `D_icode=2`. Required: `D_icode` stays 2; `ctrl_err=1`, and it remains 1 after the controls clear until `rst`.
- Saturation: `CNT_W=4`, `E_bubble=1` for 20 cycles. Required: `bubble_cycles=4'hF`, no wrap.
